// File: rtl/core_mem_sequencer.sv
// Drives the xmem/pmem fields of the 36-bit core instruction bundle: streams xmem reads, stores
// corelet results into pmem and optionally reads them back, all from a single start command.

module core_mem_sequencer #(
    parameter int unsigned addr_width = 11,
    parameter int unsigned len_width  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  readback,
    input  logic [addr_width-1:0] x_base,
    input  logic [len_width-1:0]  x_len,
    input  logic [addr_width-1:0] p_base,
    input  logic [len_width-1:0]  p_len,
    input  logic                  ofifo_valid,
    input  logic [9:0]            ctrl_in,
    output logic [35:0]           inst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_XREAD = 3'd1,
        S_WAIT  = 3'd2,
        S_PREAD = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [addr_width-1:0] r_x_base;
    logic [addr_width-1:0] w_x_base;
    logic [len_width-1:0]  r_x_len;
    logic [len_width-1:0]  w_x_len;
    logic [addr_width-1:0] r_p_base;
    logic [addr_width-1:0] w_p_base;
    logic [len_width-1:0]  r_p_len;
    logic [len_width-1:0]  w_p_len;
    logic                  r_readback;
    logic                  w_readback;

    logic [len_width-1:0]  r_xi;
    logic [len_width-1:0]  w_xi;
    logic [len_width-1:0]  r_pw;
    logic [len_width-1:0]  w_pw;
    logic [len_width-1:0]  r_pr;
    logic [len_width-1:0]  w_pr;

    logic [addr_width-1:0] r_a_xmem;
    logic [addr_width-1:0] w_a_xmem;
    logic                  r_cen_xmem;
    logic                  w_cen_xmem;
    logic [addr_width-1:0] r_a_pmem;
    logic [addr_width-1:0] w_a_pmem;
    logic                  r_cen_pmem;
    logic                  w_cen_pmem;
    logic                  r_wen_pmem;
    logic                  w_wen_pmem;

    logic [9:0]            r_ctrl;
    logic                  r_busy;
    logic                  w_busy;
    logic                  r_done;
    logic                  w_done;
    logic                  r_err;
    logic                  w_err;

    // State, run parameters and registered bundle fields
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_x_base   <= '0;
            r_x_len    <= '0;
            r_p_base   <= '0;
            r_p_len    <= '0;
            r_readback <= 1'b0;
            r_xi       <= '0;
            r_pw       <= '0;
            r_pr       <= '0;
            r_a_xmem   <= '0;
            r_cen_xmem <= 1'b1;
            r_a_pmem   <= '0;
            r_cen_pmem <= 1'b1;
            r_wen_pmem <= 1'b1;
            r_ctrl     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_x_base   <= w_x_base;
            r_x_len    <= w_x_len;
            r_p_base   <= w_p_base;
            r_p_len    <= w_p_len;
            r_readback <= w_readback;
            r_xi       <= w_xi;
            r_pw       <= w_pw;
            r_pr       <= w_pr;
            r_a_xmem   <= w_a_xmem;
            r_cen_xmem <= w_cen_xmem;
            r_a_pmem   <= w_a_pmem;
            r_cen_pmem <= w_cen_pmem;
            r_wen_pmem <= w_wen_pmem;
            r_ctrl     <= ctrl_in;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_err      <= w_err;
        end
    end

    // Next state and next bundle fields; addresses hold their value when the memory is idle
    always_comb begin
        w_next     = r_state;
        w_x_base   = r_x_base;
        w_x_len    = r_x_len;
        w_p_base   = r_p_base;
        w_p_len    = r_p_len;
        w_readback = r_readback;
        w_xi       = r_xi;
        w_pw       = r_pw;
        w_pr       = r_pr;
        w_a_xmem   = r_a_xmem;
        w_cen_xmem = 1'b1;
        w_a_pmem   = r_a_pmem;
        w_cen_pmem = 1'b1;
        w_wen_pmem = 1'b1;
        w_err      = r_err;
        w_busy     = 1'b0;
        w_done     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_x_base   = x_base;
                    w_x_len    = x_len;
                    w_p_base   = p_base;
                    w_p_len    = p_len;
                    w_readback = readback;
                    w_xi       = '0;
                    w_pw       = '0;
                    w_pr       = '0;
                    w_err      = 1'b0;
                    w_next     = (x_len == '0) ? S_WAIT : S_XREAD;
                end
                if (ofifo_valid) begin
                    w_err = 1'b1;
                end
            end
            S_XREAD: begin
                w_cen_xmem = 1'b0;
                w_a_xmem   = r_x_base + addr_width'(r_xi);
                w_xi       = r_xi + len_width'(1);
                if (w_xi == r_x_len) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((r_xi == r_x_len) && (r_pw == r_p_len)) begin
                    w_next = (r_readback && (r_p_len != '0)) ? S_PREAD : S_DONE;
                end
            end
            S_PREAD: begin
                // One idle PREAD cycle after the last read keeps done one cycle behind it
                if (r_pr == r_p_len) begin
                    w_next = S_DONE;
                end else begin
                    w_cen_pmem = 1'b0;
                    w_wen_pmem = 1'b1;
                    w_a_pmem   = r_p_base + addr_width'(r_pr);
                    w_pr       = r_pr + len_width'(1);
                end
                if (ofifo_valid) begin
                    w_err = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
                if (ofifo_valid) begin
                    w_err = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        // Result stores overlap the xmem stream; an extra result is flagged, not written
        if (((r_state == S_XREAD) || (r_state == S_WAIT)) && ofifo_valid) begin
            if (r_pw < r_p_len) begin
                w_cen_pmem = 1'b0;
                w_wen_pmem = 1'b0;
                w_a_pmem   = r_p_base + addr_width'(r_pw);
                w_pw       = r_pw + len_width'(1);
            end else begin
                w_err = 1'b1;
            end
        end

        if (abort && (r_state != S_IDLE)) begin
            w_next     = S_IDLE;
            w_cen_xmem = 1'b1;
            w_cen_pmem = 1'b1;
            w_wen_pmem = 1'b1;
            w_a_xmem   = r_a_xmem;
            w_a_pmem   = r_a_pmem;
            w_err      = r_err;
        end

        w_busy = (w_next == S_XREAD) || (w_next == S_WAIT) || (w_next == S_PREAD);
        w_done = (w_next == S_DONE);
    end

    assign inst = {r_ctrl[9:7], r_cen_pmem, r_wen_pmem, r_a_pmem,
                   r_cen_xmem, 1'b1, r_a_xmem, r_ctrl[6:0]};
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule
